uriscv_mem_arb: RTL and testbench
=================================

Name: uriscv_mem_arb

Overview:
- Sequences the core's single external memory port and shares it between the instruction-fetch requester and the data (load/store) requester.
- Data-side inputs are the combinational load/store decode outputs: read strobe, byte-write mask, address, aligned write data and misaligned flag.
- Fetch and data transactions are serialised onto a registered memory interface with a variable-latency acknowledge. Each requester receives one ack pulse with read data, or an error.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without mem_ack_i before abort with error; 0 disables the timeout.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
i_rd_i  input  1  fetch read request; held until i_ack_o
i_addr_i  input  32  fetch address (word aligned)
i_ack_o  output  1  fetch complete, one-cycle pulse
i_rdata_o  output  32  fetch data, valid with i_ack_o
i_err_o  output  1  fetch error (timeout), valid with i_ack_o
d_rd_i  input  1  load request; held until d_ack_o
d_wr_i  input  4  store byte mask; held until d_ack_o
d_addr_i  input  32  data address
d_wdata_i  input  32  lane-aligned store data
d_misaligned_i  input  1  access misaligned
d_ack_o  output  1  data complete, one-cycle pulse
d_rdata_o  output  32  load data, valid with d_ack_o
d_err_o  output  1  data error (misaligned or timeout), valid with d_ack_o
mem_rd_o  output  1  memory read strobe
mem_wr_o  output  4  memory byte-write mask
mem_addr_o  output  32  memory address
mem_wdata_o  output  32  memory write data
mem_ack_i  input  1  memory access complete
mem_rdata_i  input  32  memory read data, valid with mem_ack_i
busy_o  output  1  state is not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset wins over every other event at the same edge. Reset mid-transaction clears mem_* at that edge; no ack is issued for the aborted access.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- A data request exists when d_rd_i = 1 or d_wr_i != 0. A fetch request exists when i_rd_i = 1.
- IDLE, arbitration is fixed priority, data over fetch:
  - Data request with d_misaligned_i = 1: go to RESP with d_ack_o = 1, d_err_o = 1, d_rdata_o = 0. No memory access is issued.
  - Data request with d_misaligned_i = 0: register d_* into mem_* (mem_rd_o = d_rd_i, mem_wr_o = d_wr_i, address, write data) and go to BUSY_D.
  - Otherwise, fetch request: mem_rd_o = 1, mem_wr_o = 0, mem_addr_o = i_addr_i, mem_wdata_o = 0, and go to BUSY_I.
  - No request: stay in IDLE.
  - First mem_* assertion is one cycle after the request is seen.
- BUSY_x:
  - mem_* are held stable; requester inputs are ignored.
  - Counter increments each cycle.
  - mem_ack_i = 1: at the next edge clear mem_*, go to RESP, and pulse the owner's ack_o.
    - Owner rdata = mem_rdata_i for reads, 0 for writes; err = 0.
  - Timeout, only when TIMEOUT_CYCLES != 0: if counter == TIMEOUT_CYCLES - 1 and mem_ack_i = 0, clear mem_* and go to RESP. Owner gets ack = 1, err = 1, rdata = 0.
  - mem_ack_i on the timeout cycle counts as a normal ack.
- RESP:
  - Lasts exactly one cycle with the ack/err/rdata outputs valid; then back to IDLE and ack/err/rdata return to 0.
  - Requests are not sampled in RESP. The requester drops or changes its request in the cycle after it sees ack.
  - Minimum spacing: issue edge → ≥1 BUSY cycle → RESP → IDLE → next issue.
- Counter clears on entry to IDLE.
- mem_ack_i in IDLE or RESP is ignored.
- Latency: request to mem strobe is 1 cycle. mem_ack_i to requester ack is 1 cycle. Misaligned request to error ack is 1 cycle.
- Counter width: clog2(TIMEOUT_CYCLES + 1), minimum 1. No wrap is possible because timeout fires first.
- Starvation: fetch can only be starved by back-to-back data requests. A single-issue core cannot produce these, so no fairness logic is provided.

Test Plan:
- Fetch only: i_rd_i = 1, i_addr_i = 0x100; mem_ack_i two cycles after mem_rd_o with rdata 0xDEADBEEF → mem_rd_o = 1 with addr 0x100; i_ack_o pulses once with i_rdata_o = 0xDEADBEEF and i_err_o = 0; busy_o drops after RESP.
- Simultaneous: i_rd_i = 1 and d_wr_i = 4'b0100, d_addr_i = 0x202, d_wdata_i = 0x00AB0000 → data served first: mem_wr_o = 4'b0100, mem_wdata_o = 0x00AB0000; fetch is issued only after d_ack_o and the IDLE cycle.
- Misaligned: d_rd_i = 1, d_misaligned_i = 1, d_addr_i = 0x3 → next cycle d_ack_o = d_err_o = 1, d_rdata_o = 0; mem_rd_o stays 0 throughout.
- Timeout with TIMEOUT_CYCLES = 4: load issued, mem_ack_i never asserted → mem_rd_o high exactly 4 cycles; then d_ack_o = d_err_o = 1; a late mem_ack_i is ignored.
- Reset mid-op: rst_i = 1 during BUSY_D → all outputs 0 at the next edge; a subsequent stray mem_ack_i produces no ack.
- Back-to-back: 3 fetches at addresses 0x0, 0x4, 0x8 with 1-cycle memory latency → each completes in 4 cycles; addresses are issued in order; no duplicate acks.

Source files
------------

// File: rtl/uriscv_mem_arb.sv
// uriscv_mem_arb: arbitrates the single external memory port between the
// instruction-fetch requester and the load/store requester. Data requests
// have fixed priority over fetch. Misaligned data requests are answered with
// an error and never reach memory. A stalled access is aborted after
// TIMEOUT_CYCLES cycles without an acknowledge; 0 disables the abort.
module uriscv_mem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        i_rd_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ack_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,

  input  logic        d_rd_i,
  input  logic [3:0]  d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic        d_misaligned_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,

  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,

  output logic        busy_o
);

  // The counter only ever has to reach TIMEOUT_CYCLES-1, so it never wraps
  // while the timeout is enabled.
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast =
    CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TmoEnable = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic        mem_rd_q;
  logic [3:0]  mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        i_ack_q;
  logic        i_err_q;
  logic [31:0] i_rdata_q;
  logic        d_ack_q;
  logic        d_err_q;
  logic [31:0] d_rdata_q;

  logic        dataReq;
  logic        fetchReq;
  logic        timeoutHit;
  logic        accessDone;
  logic [31:0] respData;

  assign dataReq    = d_rd_i || (d_wr_i != 4'b0000);
  assign fetchReq   = i_rd_i;
  assign timeoutHit = TmoEnable && (cnt_q == TmoLast);
  assign accessDone = mem_ack_i || timeoutHit;
  // Writes and aborted accesses return zero data; only an acknowledged read
  // forwards the memory data.
  assign respData   = (mem_ack_i && mem_rd_q) ? mem_rdata_i : 32'h0;

  // Arbitration FSM with all requester and memory outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (dataReq && d_misaligned_i) begin
            d_ack_q   <= 1'b1;
            d_err_q   <= 1'b1;
            d_rdata_q <= 32'h0;
            state_q   <= StResp;
          end else if (dataReq) begin
            mem_rd_q    <= d_rd_i;
            mem_wr_q    <= d_wr_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            state_q     <= StBusyD;
          end else if (fetchReq) begin
            mem_rd_q    <= 1'b1;
            mem_wr_q    <= 4'b0000;
            mem_addr_q  <= i_addr_i;
            mem_wdata_q <= 32'h0;
            state_q     <= StBusyI;
          end
        end

        StBusyI, StBusyD: begin
          cnt_q <= cnt_q + CntW'(1);
          if (accessDone) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            cnt_q       <= '0;
            state_q     <= StResp;
            if (state_q == StBusyI) begin
              i_ack_q   <= 1'b1;
              i_err_q   <= !mem_ack_i;
              i_rdata_q <= respData;
            end else begin
              d_ack_q   <= 1'b1;
              d_err_q   <= !mem_ack_i;
              d_rdata_q <= respData;
            end
          end
        end

        StResp: begin
          i_ack_q   <= 1'b0;
          i_err_q   <= 1'b0;
          i_rdata_q <= 32'h0;
          d_ack_q   <= 1'b0;
          d_err_q   <= 1'b0;
          d_rdata_q <= 32'h0;
          cnt_q     <= '0;
          state_q   <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign i_ack_o     = i_ack_q;
  assign i_err_o     = i_err_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uriscv_mem_arb.sv
// Testbench for uriscv_mem_arb: directed scenarios with hand-computed
// expectations, plus a transaction-level model compared on every cycle.
module tb_uriscv_mem_arb;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_rd_i;
  logic [31:0] i_addr_i;
  logic        i_ack_o;
  logic [31:0] i_rdata_o;
  logic        i_err_o;
  logic        d_rd_i;
  logic [3:0]  d_wr_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_misaligned_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  // Memory responder controls
  int          memLat     = 1;
  bit          memNoAck   = 1'b0;
  bit          forceAck   = 1'b0;
  bit          memUseAddr = 1'b0;
  logic [31:0] memData    = 32'h0;
  int          memCnt     = 0;

  uriscv_mem_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .i_rd_i         (i_rd_i),
    .i_addr_i       (i_addr_i),
    .i_ack_o        (i_ack_o),
    .i_rdata_o      (i_rdata_o),
    .i_err_o        (i_err_o),
    .d_rd_i         (d_rd_i),
    .d_wr_i         (d_wr_i),
    .d_addr_i       (d_addr_i),
    .d_wdata_i      (d_wdata_i),
    .d_misaligned_i (d_misaligned_i),
    .d_ack_o        (d_ack_o),
    .d_rdata_o      (d_rdata_o),
    .d_err_o        (d_err_o),
    .mem_rd_o       (mem_rd_o),
    .mem_wr_o       (mem_wr_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .busy_o         (busy_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iRd, input logic [31:0] iAddr,
                               input logic dRd, input logic [3:0] dWr,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic dMis);
    i_rd_i         = iRd;
    i_addr_i       = iAddr;
    d_rd_i         = dRd;
    d_wr_i         = dWr;
    d_addr_i       = dAddr;
    d_wdata_i      = dWdata;
    d_misaligned_i = dMis;
  endtask

  // Wait (bounded) for the selected requester's ack; capture its payload.
  task automatic waitAck(input bit isData, input int maxCyc, input string name,
                         output logic [31:0] rdata, output logic err, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    rdata  = 32'h0;
    err    = 1'b0;
    while (!found && cycles < maxCyc) begin
      @(negedge clk);
      cycles++;
      if (isData ? d_ack_o : i_ack_o) begin
        found = 1'b1;
        rdata = isData ? d_rdata_o : i_rdata_o;
        err   = isData ? d_err_o : i_err_o;
      end
    end
    if (!found) checkOutput({name, "_ack_seen"}, 32'd0, 32'd1);
  endtask

  // Memory model: acks memLat cycles after the strobe appears, unless muted;
  // forceAck injects stray acks regardless of the strobe.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd_o || (mem_wr_o != 4'b0000)) begin
        mem_ack_i = forceAck || (!memNoAck && memCnt == memLat);
        memCnt++;
      end else begin
        mem_ack_i = forceAck;
        memCnt    = 0;
      end
      if (mem_ack_i)
        mem_rdata_i = memUseAddr ? (mem_addr_o ^ 32'hA5A50000) : memData;
      else
        mem_rdata_i = 32'h5A5A5A5A;
    end
  end

  // Reference model state: at most one access in flight plus a pending response.
  logic        mInflight = 1'b0;
  logic        mIsData   = 1'b0;
  logic        mIsRead   = 1'b0;
  logic [3:0]  mWr       = 4'b0;
  logic [31:0] mAddr     = 32'h0;
  logic [31:0] mWdata    = 32'h0;
  int          mBusyCycles = 0;
  logic        mResp     = 1'b0;
  logic        eIAck = 1'b0, eIErr = 1'b0, eDAck = 1'b0, eDErr = 1'b0;
  logic [31:0] eIRdata = 32'h0, eDRdata = 32'h0;

  // Transaction-level model advanced on each rising edge from the inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        mInflight = 1'b0;
        mResp     = 1'b0;
        {eIAck, eIErr, eDAck, eDErr} = 4'b0;
        eIRdata = 32'h0;
        eDRdata = 32'h0;
      end else if (mResp) begin
        mResp = 1'b0;
        {eIAck, eIErr, eDAck, eDErr} = 4'b0;
        eIRdata = 32'h0;
        eDRdata = 32'h0;
      end else if (mInflight) begin
        mBusyCycles++;
        if (mem_ack_i || (TMO != 0 && mBusyCycles == TMO)) begin
          mInflight = 1'b0;
          mResp     = 1'b1;
          if (mIsData) begin
            eDAck   = 1'b1;
            eDErr   = !mem_ack_i;
            eDRdata = (mem_ack_i && mIsRead) ? mem_rdata_i : 32'h0;
          end else begin
            eIAck   = 1'b1;
            eIErr   = !mem_ack_i;
            eIRdata = mem_ack_i ? mem_rdata_i : 32'h0;
          end
        end
      end else if (d_rd_i || d_wr_i != 4'b0) begin
        if (d_misaligned_i) begin
          mResp   = 1'b1;
          eDAck   = 1'b1;
          eDErr   = 1'b1;
          eDRdata = 32'h0;
        end else begin
          mInflight   = 1'b1;
          mIsData     = 1'b1;
          mIsRead     = d_rd_i;
          mWr         = d_wr_i;
          mAddr       = d_addr_i;
          mWdata      = d_wdata_i;
          mBusyCycles = 0;
        end
      end else if (i_rd_i) begin
        mInflight   = 1'b1;
        mIsData     = 1'b0;
        mIsRead     = 1'b1;
        mWr         = 4'b0;
        mAddr       = i_addr_i;
        mWdata      = 32'h0;
        mBusyCycles = 0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        checkOutput("cmp_mem_rd",    32'(mem_rd_o),    32'(mInflight && mIsRead));
        checkOutput("cmp_mem_wr",    32'(mem_wr_o),    32'(mInflight ? mWr : 4'b0));
        checkOutput("cmp_mem_addr",  mem_addr_o,       mInflight ? mAddr : 32'h0);
        checkOutput("cmp_mem_wdata", mem_wdata_o,      mInflight ? mWdata : 32'h0);
        checkOutput("cmp_busy",      32'(busy_o),      32'(mInflight || mResp));
        checkOutput("cmp_i_ack",     32'(i_ack_o),     32'(eIAck));
        checkOutput("cmp_i_err",     32'(i_err_o),     32'(eIErr));
        checkOutput("cmp_i_rdata",   i_rdata_o,        eIRdata);
        checkOutput("cmp_d_ack",     32'(d_ack_o),     32'(eDAck));
        checkOutput("cmp_d_err",     32'(d_err_o),     32'(eDErr));
        checkOutput("cmp_d_rdata",   d_rdata_o,        eDRdata);
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          rdHigh;
    logic [31:0] issued [8];
    int          nIss;
    int          nAck;
    int          ackCyc [4];
    logic        prevRd;
    logic [31:0] expB2B [3];

    rst_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   32'(busy_o),   32'd0);
    checkOutput("reset_mem_rd", 32'(mem_rd_o), 32'd0);
    checkOutput("reset_i_ack",  32'(i_ack_o),  32'd0);
    checkOutput("reset_d_ack",  32'(d_ack_o),  32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Fetch only, memory acks two cycles after the strobe.
    $display("[TB] fetch only");
    memLat  = 2;
    memData = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h100, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("fetch_mem_rd",   32'(mem_rd_o), 32'd1);
    checkOutput("fetch_mem_addr", mem_addr_o,    32'h100);
    waitAck(1'b0, 10, "fetch", rd, er, cyc);
    i_rd_i = 1'b0;
    checkOutput("fetch_rdata", rd,       32'hDEADBEEF);
    checkOutput("fetch_err",   32'(er),  32'd0);
    checkOutput("fetch_cycles", 32'(cyc), 32'd3);
    @(negedge clk);
    checkOutput("fetch_ack_pulse", 32'(i_ack_o), 32'd0);
    checkOutput("fetch_idle_busy", 32'(busy_o),  32'd0);

    // Simultaneous data store and fetch: data wins.
    $display("[TB] simultaneous");
    memLat  = 1;
    memData = 32'h12345678;
    applyStimulus(1'b1, 32'h40, 1'b0, 4'b0100, 32'h202, 32'h00AB0000, 1'b0);
    @(negedge clk);
    checkOutput("sim_mem_wr",    32'(mem_wr_o), 32'h4);
    checkOutput("sim_mem_wdata", mem_wdata_o,   32'h00AB0000);
    checkOutput("sim_mem_addr",  mem_addr_o,    32'h202);
    checkOutput("sim_mem_rd",    32'(mem_rd_o), 32'd0);
    waitAck(1'b1, 10, "store", rd, er, cyc);
    d_wr_i = 4'b0;
    checkOutput("store_rdata", rd,      32'h0);
    checkOutput("store_err",   32'(er), 32'd0);
    @(negedge clk);
    checkOutput("fetch_wait_idle", 32'(mem_rd_o), 32'd0);
    @(negedge clk);
    checkOutput("fetch_after_data",      32'(mem_rd_o), 32'd1);
    checkOutput("fetch_after_data_addr", mem_addr_o,    32'h40);
    waitAck(1'b0, 10, "fetch2", rd, er, cyc);
    i_rd_i = 1'b0;
    checkOutput("fetch2_rdata", rd, 32'h12345678);

    // Misaligned load: error ack one cycle later, no memory access.
    $display("[TB] misaligned");
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0, 32'h3, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("mis_ack",    32'(d_ack_o),  32'd1);
    checkOutput("mis_err",    32'(d_err_o),  32'd1);
    checkOutput("mis_rdata",  d_rdata_o,     32'h0);
    checkOutput("mis_mem_rd", 32'(mem_rd_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mis_ack_pulse", 32'(d_ack_o),  32'd0);
    checkOutput("mis_mem_rd2",   32'(mem_rd_o), 32'd0);

    // Timeout: memory never answers.
    $display("[TB] timeout");
    memNoAck = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0, 32'h80, 32'h0, 1'b0);
    rdHigh = 0;
    cyc    = 0;
    while (!d_ack_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_o) rdHigh++;
    end
    checkOutput("tmo_ack",      32'(d_ack_o), 32'd1);
    checkOutput("tmo_err",      32'(d_err_o), 32'd1);
    checkOutput("tmo_rdata",    d_rdata_o,    32'h0);
    checkOutput("tmo_rd_high",  32'(rdHigh),  32'd4);
    d_rd_i   = 1'b0;
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    @(negedge clk);
    checkOutput("tmo_late_ack_d", 32'(d_ack_o), 32'd0);
    checkOutput("tmo_late_ack_i", 32'(i_ack_o), 32'd0);
    checkOutput("tmo_late_busy",  32'(busy_o),  32'd0);
    memNoAck = 1'b0;

    // Reset in the middle of a data access.
    $display("[TB] reset mid-op");
    memNoAck = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0, 32'h44, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_issued", 32'(mem_rd_o), 32'd1);
    @(negedge clk);
    rst_i  = 1'b1;
    d_rd_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_mem_rd", 32'(mem_rd_o), 32'd0);
    checkOutput("rst_mid_addr",   mem_addr_o,    32'h0);
    checkOutput("rst_mid_busy",   32'(busy_o),   32'd0);
    rst_i    = 1'b0;
    memNoAck = 1'b0;
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    @(negedge clk);
    checkOutput("rst_stray_d_ack", 32'(d_ack_o), 32'd0);
    checkOutput("rst_stray_i_ack", 32'(i_ack_o), 32'd0);
    @(negedge clk);
    checkOutput("rst_stray_busy", 32'(busy_o), 32'd0);

    // Back-to-back fetches with 1-cycle memory latency.
    $display("[TB] back-to-back");
    memLat     = 1;
    memUseAddr = 1'b1;
    expB2B[0]  = 32'hA5A50000;
    expB2B[1]  = 32'hA5A50004;
    expB2B[2]  = 32'hA5A50008;
    nIss   = 0;
    nAck   = 0;
    prevRd = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd_o && !prevRd && nIss < 8) begin
        issued[nIss] = mem_addr_o;
        nIss++;
      end
      prevRd = mem_rd_o;
      if (i_ack_o) begin
        if (nAck < 3) begin
          checkOutput("b2b_rdata", i_rdata_o, expB2B[nAck]);
          ackCyc[nAck] = c;
        end
        nAck++;
        if (nAck < 3) i_addr_i = 32'(nAck * 4);
        else          i_rd_i   = 1'b0;
      end
    end
    memUseAddr = 1'b0;
    checkOutput("b2b_issue_count", 32'(nIss), 32'd3);
    checkOutput("b2b_ack_count",   32'(nAck), 32'd3);
    if (nIss >= 3) begin
      checkOutput("b2b_addr0", issued[0], 32'h0);
      checkOutput("b2b_addr1", issued[1], 32'h4);
      checkOutput("b2b_addr2", issued[2], 32'h8);
    end
    if (nAck >= 3) begin
      checkOutput("b2b_spacing1", 32'(ackCyc[1] - ackCyc[0]), 32'd4);
      checkOutput("b2b_spacing2", 32'(ackCyc[2] - ackCyc[1]), 32'd4);
    end

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
